// File: rtl/europa_lpddr_perf_cnt_sampler.sv
`default_nettype none
// ============================================================================
// Module : europa_lpddr_perf_cnt_sampler
// Desc   : Ctrl-domain window sampler for a bank of async LPDDR perf counters.
//          Optional back-to-back windows: EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
// Rev    : 1.0 - initial release
// ============================================================================
module europa_lpddr_perf_cnt_sampler #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int WINDOW_WIDTH  = 32,
    parameter int SETTLE_CYCLES = 12
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic                                  i_abort,
    input  logic [WINDOW_WIDTH-1:0]               i_window_len,
`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
    input  logic                                  i_continuous,
`endif
    output logic                                  o_cnt_en,
    output logic                                  o_cnt_flush,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] i_cnt_value,
    output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] o_sample,
    output logic [WINDOW_WIDTH-1:0]               o_window_remaining,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_aborted
);

    localparam int                  c_SW          = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_SW-1:0]     c_SETTLE_LOAD = c_SW'(SETTLE_CYCLES);
    localparam logic [c_SW-1:0]     c_SETTLE_ONE  = c_SW'(1);
    localparam logic [WINDOW_WIDTH-1:0] c_WIN_ONE = WINDOW_WIDTH'(1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_settle_check
            $error("SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_STOP    = 3'd4,
        S_CAPTURE = 3'd5
    } state_t;

    state_t                                r_state;
    state_t                                w_next_state;
    logic                                  w_take_abort;
    logic                                  w_load_win;
    logic [c_SW-1:0]                       r_settle;
    logic [WINDOW_WIDTH-1:0]               r_win_len;
    logic [WINDOW_WIDTH-1:0]               r_remaining;
    logic                                  r_cnt_en;
    logic                                  r_cnt_flush;
    logic                                  r_busy;
    logic                                  r_done;
    logic                                  r_aborted;
    logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] r_sample;

    always_comb begin
        w_next_state = r_state;
        w_load_win   = 1'b0;
        w_take_abort = i_abort && (r_state inside {S_FLUSH, S_SETTLE, S_RUN, S_STOP});
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    w_next_state = S_FLUSH;
                    w_load_win   = 1'b1;
                end
            end
            S_FLUSH:  w_next_state = S_SETTLE;
            S_SETTLE: if (r_settle == c_SETTLE_ONE) w_next_state = S_RUN;
            S_RUN:    if (r_remaining == c_WIN_ONE) w_next_state = S_STOP;
            S_STOP:   if (r_settle == c_SETTLE_ONE) w_next_state = S_CAPTURE;
            S_CAPTURE: begin
                w_next_state = S_IDLE;
`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
                if (i_continuous) begin
                    w_next_state = S_FLUSH;
                    w_load_win   = 1'b1;
                end
`endif
            end
            default:  w_next_state = S_IDLE;
        endcase
        if (w_take_abort) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every output is a registered decode of the next state, so each one
    // changes on the same edge the FSM enters the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle    <= '0;
            r_win_len   <= '0;
            r_remaining <= '0;
            r_cnt_en    <= 1'b0;
            r_cnt_flush <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_sample    <= '0;
        end else begin
            if (w_load_win) begin
                r_win_len <= (i_window_len == '0) ? c_WIN_ONE : i_window_len;
            end

            if (w_next_state == S_SETTLE || w_next_state == S_STOP) begin
                r_settle <= (r_state == w_next_state) ? (r_settle - c_SETTLE_ONE) : c_SETTLE_LOAD;
            end else begin
                r_settle <= '0;
            end

            if (w_next_state == S_RUN) begin
                r_remaining <= (r_state == S_RUN) ? (r_remaining - c_WIN_ONE) : r_win_len;
            end else begin
                r_remaining <= '0;
            end

            r_cnt_en    <= (w_next_state == S_RUN);
            r_cnt_flush <= (w_next_state == S_FLUSH);
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_CAPTURE);
            r_aborted   <= w_take_abort;

            if (w_next_state == S_CAPTURE) begin
                r_sample <= i_cnt_value;
            end
        end
    end

    assign o_cnt_en           = r_cnt_en;
    assign o_cnt_flush        = r_cnt_flush;
    assign o_sample           = r_sample;
    assign o_window_remaining = r_remaining;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_aborted          = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_europa_lpddr_perf_cnt_sampler.sv
`default_nettype none
// ============================================================================
// Module : tb_europa_lpddr_perf_cnt_sampler
// Desc   : Randomized window/abort/collision bench with counter-bank stand-in.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_europa_lpddr_perf_cnt_sampler;

    localparam int S = 12;

    logic          i_clk = 1'b0;
    logic          cnt_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [31:0]   i_window_len = '0;
`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
    logic          i_continuous = 1'b0;
`endif
    logic          o_cnt_en;
    logic          o_cnt_flush;
    logic [127:0]  i_cnt_value;
    logic [127:0]  o_sample;
    logic [31:0]   o_window_remaining;
    logic          o_busy;
    logic          o_done;
    logic          o_aborted;

    int n_checks = 0;
    int n_fails  = 0;

    europa_lpddr_perf_cnt_sampler #(
        .NUM_COUNTERS (4),
        .COUNTER_WIDTH(32),
        .WINDOW_WIDTH (32),
        .SETTLE_CYCLES(S)
    ) u_dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_start           (i_start),
        .i_abort           (i_abort),
        .i_window_len      (i_window_len),
`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
        .i_continuous      (i_continuous),
`endif
        .o_cnt_en          (o_cnt_en),
        .o_cnt_flush       (o_cnt_flush),
        .i_cnt_value       (i_cnt_value),
        .o_sample          (o_sample),
        .o_window_remaining(o_window_remaining),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_aborted         (o_aborted)
    );

    // ctrl clock 30 ns; count clock 10 ns, edges offset so none coincide
    always #15 i_clk = ~i_clk;
    initial begin
        #2;
        forever #5 cnt_clk = ~cnt_clk;
    end

    // Counter-bank stand-in: 2-flop synced enable/flush, rates 1, 1/2, 0, 1/4
    logic [1:0]  en_sync = '0;
    logic [1:0]  fl_sync = '0;
    logic [31:0] en_edges = '0;
    logic [31:0] cnt0 = '0, cnt1 = '0, cnt2 = '0, cnt3 = '0;
    always @(posedge cnt_clk) begin
        en_sync <= {en_sync[0], o_cnt_en};
        fl_sync <= {fl_sync[0], o_cnt_flush};
        if (fl_sync[1]) begin
            en_edges <= '0;
            cnt0 <= '0; cnt1 <= '0; cnt2 <= '0; cnt3 <= '0;
        end else if (en_sync[1]) begin
            en_edges <= en_edges + 1;
            cnt0 <= cnt0 + 1;
            if (en_edges[0]) cnt1 <= cnt1 + 1;
            if (en_edges[1:0] == 2'b11) cnt3 <= cnt3 + 1;
        end
    end
    assign i_cnt_value = {cnt3, cnt2, cnt1, cnt0};

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // A window of L ctrl cycles is 3L count-clock edges at the counters.
    function automatic logic [127:0] model_sample(input int L);
        int e;
        e = 3 * L;
        return {32'(e / 4), 32'd0, 32'(e / 2), 32'(e)};
    endfunction

    // ac: cycle whose i_abort is driven high (0 = never); st: stray start cycle
    task automatic run_window(input int len, input int ac, input int st);
        int L, cyc, flush_cyc, flush_cnt, en_first, en_cnt, busy_cnt;
        int done_cyc, done_cnt, abort_cnt, rem_bad, last_stop, exp_en;
        bit ended, aborting;
        logic [127:0] prev;
        L = (len == 0) ? 1 : len;
        flush_cyc = -1; flush_cnt = 0; en_first = -1; en_cnt = 0; busy_cnt = 0;
        done_cyc = -1; done_cnt = 0; abort_cnt = 0; rem_bad = 0; ended = 0;
        last_stop = 1 + 2 * S + L;
        aborting = (ac >= 1) && (ac <= last_stop);
        prev = o_sample;
        i_window_len = 32'(len);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_window_len = $urandom;
        for (int c = 1; c <= 2 * S + L + 8; c++) begin
            cyc = c;
            if (o_cnt_flush) begin
                flush_cnt++;
                if (flush_cyc < 0) flush_cyc = cyc;
            end
            if (o_cnt_en) begin
                if (en_first < 0) en_first = cyc;
                if (o_window_remaining != 32'(L - en_cnt)) rem_bad++;
                en_cnt++;
            end else if (o_window_remaining != 0) begin
                rem_bad++;
            end
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (o_aborted) abort_cnt++;
            i_abort = 1'b0;
            i_start = 1'b0;
            if (!o_busy) begin
                ended = 1;
                break;
            end
            if (cyc == ac) i_abort = 1'b1;
            if (cyc == st) i_start = 1'b1;
            @(posedge i_clk); #1;
        end
        i_abort = 1'b0;
        i_start = 1'b0;
        check_val("timeout", ended, 1'b1);
        check_val("flush_cnt", flush_cnt, 1);
        check_val("flush_cyc", flush_cyc, 1);
        check_val("remaining", rem_bad, 0);
        if (aborting) begin
            exp_en = ac - (2 + S) + 1;
            if (exp_en < 0) exp_en = 0;
            if (exp_en > L) exp_en = L;
            check_val("ab_en_cnt", en_cnt, exp_en);
            check_val("ab_busy", busy_cnt, ac);
            check_val("ab_pulse", abort_cnt, 1);
            check_val("ab_done", done_cnt, 0);
            check_val("ab_sample", o_sample, prev);
        end else begin
            check_val("en_first", en_first, 2 + S);
            check_val("en_cnt", en_cnt, L);
            check_val("done_cyc", done_cyc, 2 + 2 * S + L);
            check_val("done_cnt", done_cnt, 1);
            check_val("busy_cnt", busy_cnt, 2 + 2 * S + L);
            check_val("no_abort", abort_cnt, 0);
            check_val("sample", o_sample, model_sample(L));
        end
        @(posedge i_clk); #1;
        check_val("aborted_1cyc", o_aborted, 1'b0);
    endtask

`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
    task automatic run_continuous(input int len);
        int dones, last;
        bit ended;
        dones = 0; last = -1; ended = 0;
        i_continuous = 1'b1;
        i_window_len = 32'(len);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (!o_busy) begin
                ended = 1;
                break;
            end
            if (o_done) begin
                dones++;
                check_val("c_sample", o_sample, model_sample(len));
                if (last >= 0) check_val("c_gap", c - last, 2 * S + len + 2);
                last = c;
            end
            if (dones == 2 && o_cnt_en) i_continuous = 1'b0;
            @(posedge i_clk); #1;
        end
        i_continuous = 1'b0;
        check_val("c_timeout", ended, 1'b1);
        check_val("c_dones", dones, 3);
    endtask
`endif

    initial begin
        int len, ac, st, sel;
        // reset state
        #7;
        check_val("rst_en", o_cnt_en, 1'b0);
        check_val("rst_flush", o_cnt_flush, 1'b0);
        check_val("rst_busy", o_busy, 1'b0);
        check_val("rst_done", o_done, 1'b0);
        check_val("rst_sample", o_sample, '0);
        check_val("rst_remain", o_window_remaining, '0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // basic window, len=0, abort in RUN at remaining 40
        run_window(100, 0, 0);
        run_window(0, 0, 0);
        run_window(100, 2 + S + 100 - 40, 0);

        // start & abort in the same IDLE cycle
        i_start = 1'b1; i_abort = 1'b1; i_window_len = 32'd5;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
        check_val("coll_busy", o_busy, 1'b0);
        check_val("coll_flush", o_cnt_flush, 1'b0);
        check_val("coll_aborted", o_aborted, 1'b0);
        // abort alone in IDLE
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        check_val("idle_abort", o_aborted, 1'b0);

        // start during RUN ignored; abort in CAPTURE ignored; abort in SETTLE/STOP
        run_window(20, 0, 2 + S + 5);
        run_window(10, 2 + 2 * S + 10, 0);
        run_window(10, 5, 0);
        run_window(10, 2 + S + 10 + 3, 0);

        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(0, 40);
            sel = $urandom_range(0, 2);
            ac  = (sel == 0) ? $urandom_range(1, 2 + 2 * S + ((len == 0) ? 1 : len)) : 0;
            st  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1 + 2 * S + len) : 0;
            run_window(len, ac, st);
        end

        // async reset mid-window drops enable immediately
        i_window_len = 32'd30;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (S + 6) @(posedge i_clk);
        #5;
        check_val("pre_rst_en", o_cnt_en, 1'b1);
        i_rst_n = 1'b0;
        #1;
        check_val("arst_en", o_cnt_en, 1'b0);
        check_val("arst_busy", o_busy, 1'b0);
        check_val("arst_sample", o_sample, '0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_window(7, 0, 0);

`ifdef EUROPA_LPDDR_PERF_SAMPLER_CONTINUOUS_EN
        run_continuous(50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
